// File: rtl/display_pkg.sv
// Character codes and the active-low seven-segment glyph table for the panel.
package display_pkg;

  localparam logic [5:0] CHAR_BLANK = 6'd10;
  localparam logic [5:0] CHAR_A     = 6'd11;
  localparam logic [5:0] CHAR_B     = 6'd12;
  localparam logic [5:0] CHAR_C     = 6'd13;
  localparam logic [5:0] CHAR_D     = 6'd14;
  localparam logic [5:0] CHAR_E     = 6'd15;
  localparam logic [5:0] CHAR_F     = 6'd16;
  localparam logic [5:0] CHAR_G     = 6'd17;
  localparam logic [5:0] CHAR_H     = 6'd18;
  localparam logic [5:0] CHAR_I     = 6'd19;
  localparam logic [5:0] CHAR_J     = 6'd20;
  localparam logic [5:0] CHAR_K     = 6'd21;
  localparam logic [5:0] CHAR_L     = 6'd22;
  localparam logic [5:0] CHAR_M     = 6'd23;
  localparam logic [5:0] CHAR_N     = 6'd24;
  localparam logic [5:0] CHAR_O     = 6'd25;
  localparam logic [5:0] CHAR_P     = 6'd26;
  localparam logic [5:0] CHAR_Q     = 6'd27;
  localparam logic [5:0] CHAR_R     = 6'd28;
  localparam logic [5:0] CHAR_S     = 6'd29;
  localparam logic [5:0] CHAR_T     = 6'd30;
  localparam logic [5:0] CHAR_U     = 6'd31;
  localparam logic [5:0] CHAR_DASH  = 6'd32;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Indexed by character code; bit order {g,f,e,d,c,b,a}, 0 lights a segment.
  localparam logic [6:0] GLYPH [64] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10,
    7'h7F,
    7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E, 7'h42, 7'h09, 7'h4F, 7'h61,
    7'h0A, 7'h47, 7'h6A, 7'h2B, 7'h23, 7'h0C, 7'h18, 7'h2F, 7'h12, 7'h07,
    7'h41,
    7'h3F,
    7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F,
    7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F,
    7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F,
    7'h7F
  };

endpackage

// File: rtl/char_to_seg.sv
// Combinational character-code to segment-pattern lookup.
module char_to_seg
  import display_pkg::*;
(
  input  logic [5:0] code,
  output logic [6:0] seg
);

  always_comb seg = GLYPH[code];

endmodule

// File: rtl/display_scan.sv
// Six-digit seven-segment scanner: shadow capture, slot/digit sequencing,
// guard blanking between digits and per-digit blink.
module display_scan
  import display_pkg::*;
#(
  parameter int SCAN_DIV  = 50000,
  parameter int GUARD     = 2,
  parameter int BLINK_DIV = 12500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [5:0] data1,
  input  logic [5:0] data2,
  input  logic [5:0] data3,
  input  logic [5:0] data4,
  input  logic [5:0] data5,
  input  logic [5:0] data6,
  input  logic [5:0] blink_mask,
  output logic [6:0] seg,
  output logic [5:0] an
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [SW-1:0] SLOT_TC  = SW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] GUARD_N  = SW'(GUARD);
  localparam logic [BW-1:0] BLINK_TC = BW'(BLINK_DIV - 1);

  logic [SW-1:0] slot_q, slot_d;
  logic [2:0]    idx_q, idx_d;
  logic [BW-1:0] blink_q, blink_d;
  logic          phase_q, phase_d;
  logic [5:0]    sh_q [6];
  logic [5:0]    sh_d [6];
  logic [6:0]    seg_q, seg_d;
  logic [5:0]    an_q, an_d;
  logic [5:0]    cur_code;
  logic [6:0]    glyph;
  logic          slot_tc;

  always_comb cur_code = sh_q[idx_q];

  char_to_seg u_char_to_seg (
    .code (cur_code),
    .seg  (glyph)
  );

  always_comb begin
    slot_tc = (slot_q == SLOT_TC);
    slot_d  = slot_tc ? '0 : slot_q + SW'(1);
    idx_d   = idx_q;
    if (slot_tc) idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;

    blink_d = (blink_q == BLINK_TC) ? '0 : blink_q + BW'(1);
    phase_d = (blink_q == BLINK_TC) ? ~phase_q : phase_q;

    sh_d = sh_q;
    if (load) sh_d = '{data1, data2, data3, data4, data5, data6};

    // Outputs reflect the current state; they land one cycle later.
    an_d  = 6'b111111;
    seg_d = SEG_OFF;
    if (slot_q >= GUARD_N) begin
      an_d  = ~(6'b000001 << idx_q);
      seg_d = (phase_q && blink_mask[idx_q]) ? SEG_OFF : glyph;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q  <= '0;
      idx_q   <= 3'd0;
      blink_q <= '0;
      phase_q <= 1'b0;
      sh_q    <= '{CHAR_BLANK, CHAR_BLANK, CHAR_BLANK, CHAR_BLANK, CHAR_BLANK, CHAR_BLANK};
      seg_q   <= SEG_OFF;
      an_q    <= 6'b111111;
    end else begin
      slot_q  <= slot_d;
      idx_q   <= idx_d;
      blink_q <= blink_d;
      phase_q <= phase_d;
      sh_q    <= sh_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;

endmodule
